// File: rtl/serdes_pkg.sv
// Shared types and width helpers for the AXIS beat packer and its matching unpacker.
package serdes_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   localparam int DEFAULT_IN_WIDTH   = 8;
   localparam int DEFAULT_PACK_RATIO = 4;

   // Packed lanes plus one frame-end flag in the MSB.
   function automatic int fifo_width(input int in_width, input int pack_ratio);
      return in_width * pack_ratio + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_writer.sv
// AXI-Stream slave packing PACK_RATIO beats into one FIFO word with a frame-end flag in the MSB.
// Optional build macro AXIS_FIFO_WRITER_DROP_EN: tready tied high, beats seen while holding are counted on o_drops.
module axis_fifo_writer
   import serdes_pkg::*;
#(
   parameter int IN_WIDTH    = DEFAULT_IN_WIDTH,
   parameter int PACK_RATIO  = DEFAULT_PACK_RATIO,
   parameter int FRAME_CNT_W = 16,
   localparam int FIFO_WIDTH = fifo_width(IN_WIDTH, PACK_RATIO)
) (
   input  logic                   i_wclk,
   input  logic                   i_rst_n,
   input  logic [IN_WIDTH-1:0]    s_axis_tdata,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic                   o_wr,
   output logic [FIFO_WIDTH-1:0]  o_wdata,
   input  logic                   i_wfull,
   output logic [FRAME_CNT_W-1:0] o_frames,
`ifdef AXIS_FIFO_WRITER_DROP_EN
   output logic [15:0]            o_drops,
`endif
   output logic                   o_busy
);

   localparam int CNT_W = $clog2(PACK_RATIO);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PACK_RATIO - 1);

   pack_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [FIFO_WIDTH-1:0]  pack_q, pack_d;
   logic [FRAME_CNT_W-1:0] frames_q, frames_d;
`ifdef AXIS_FIFO_WRITER_DROP_EN
   logic [15:0]            drops_q, drops_d;
`endif

   always_ff @(posedge i_wclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         pack_q   <= '0;
         frames_q <= '0;
`ifdef AXIS_FIFO_WRITER_DROP_EN
         drops_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pack_q   <= pack_d;
         frames_q <= frames_d;
`ifdef AXIS_FIFO_WRITER_DROP_EN
         drops_q  <= drops_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pack_d        = pack_q;
      frames_d      = frames_q;
      s_axis_tready = 1'b0;
      o_wr          = 1'b0;
`ifdef AXIS_FIFO_WRITER_DROP_EN
      drops_d       = drops_q;
`endif

      case (state_q)
         FILL: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               for (int k = 0; k < PACK_RATIO; k++) begin
                  if (cnt_q == CNT_W'(k)) begin
                     pack_d[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
                  end
               end
               // A short frame closes the word early; unused upper lanes stay zero.
               if (cnt_q == CNT_MAX || s_axis_tlast) begin
                  pack_d[FIFO_WIDTH-1] = s_axis_tlast;
                  state_d              = HOLD;
                  cnt_d                = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            o_wr = !i_wfull;
            if (!i_wfull) begin
               state_d = FILL;
               pack_d  = '0;
               if (pack_q[FIFO_WIDTH-1]) begin
                  frames_d = frames_q + 1'b1;
               end
            end
`ifdef AXIS_FIFO_WRITER_DROP_EN
            if (s_axis_tvalid && drops_q != 16'hFFFF) begin
               drops_d = drops_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d = FILL;
         end
      endcase

`ifdef AXIS_FIFO_WRITER_DROP_EN
      s_axis_tready = 1'b1;
`endif
   end

   assign o_wdata  = pack_q;
   assign o_frames = frames_q;
   assign o_busy   = (state_q == HOLD) || (cnt_q != '0);
`ifdef AXIS_FIFO_WRITER_DROP_EN
   assign o_drops  = drops_q;
`endif

endmodule

// File: tb/tb_axis_fifo_writer.sv
// Directed self-checking bench for axis_fifo_writer (default parameters, 8-bit beats packed by 4).
module tb_axis_fifo_writer;

   localparam int IN_WIDTH   = 8;
   localparam int FIFO_WIDTH = 33;

   logic                  clk;
   logic                  rst_n;
   logic [IN_WIDTH-1:0]   tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;
   logic                  wr;
   logic [FIFO_WIDTH-1:0] wdata;
   logic                  wfull;
   logic [15:0]           frames;
   logic                  busy;
`ifdef AXIS_FIFO_WRITER_DROP_EN
   logic [15:0]           drops;
`endif

   int checks = 0;
   int errors = 0;

   axis_fifo_writer dut (
      .i_wclk        (clk),
      .i_rst_n       (rst_n),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tlast  (tlast),
      .s_axis_tready (tready),
      .o_wr          (wr),
      .o_wdata       (wdata),
      .i_wfull       (wfull),
      .o_frames      (frames),
`ifdef AXIS_FIFO_WRITER_DROP_EN
      .o_drops       (drops),
`endif
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge, then let state and combinational outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      tdata  = d;
      tlast  = l;
      tvalid = 1'b1;
      tick();
      tvalid = 1'b0;
      tlast  = 1'b0;
      #1;
   endtask

   logic [FIFO_WIDTH-1:0] held;

   initial begin
      rst_n  = 1'b0;
      tdata  = '0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      wfull  = 1'b0;
      #12;
      chk("rst_tready", 64'(tready), 64'd1);
      chk("rst_wr",     64'(wr),     64'd0);
      chk("rst_wdata",  64'(wdata),  64'd0);
      chk("rst_busy",   64'(busy),   64'd0);
      chk("rst_frames", 64'(frames), 64'd0);
      rst_n = 1'b1;
      tick();

      // Full four-beat frame
      beat(8'h11, 1'b0);
      chk("t1_busy_partial", 64'(busy), 64'd1);
      beat(8'h22, 1'b0);
      beat(8'h33, 1'b0);
      beat(8'h44, 1'b1);
      chk("t1_wr",     64'(wr),     64'd1);
      chk("t1_wdata",  64'(wdata),  64'h1_4433_2211);
      chk("t1_tready", 64'(tready), 64'd0);
      tick();
      chk("t1_wr_done",  64'(wr),     64'd0);
      chk("t1_frames",   64'(frames), 64'd1);
      chk("t1_tready_b", 64'(tready), 64'd1);
      chk("t1_busy_idle", 64'(busy),  64'd0);

      // Short frame, upper lanes zero
      beat(8'hAA, 1'b0);
      beat(8'hBB, 1'b1);
      chk("t2_wr",    64'(wr),    64'd1);
      chk("t2_wdata", 64'(wdata), 64'h1_0000_BBAA);
      tick();
      chk("t2_wr_once", 64'(wr),     64'd0);
      chk("t2_frames",  64'(frames), 64'd2);

      // FIFO full while holding
      wfull = 1'b1;
      beat(8'h55, 1'b0);
      beat(8'h56, 1'b0);
      beat(8'h57, 1'b0);
      beat(8'h58, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_wr",     64'(wr),     64'd0);
         chk("t3_hold_wdata",  64'(wdata),  64'h1_5857_5655);
         chk("t3_hold_tready", 64'(tready), 64'd0);
         tick();
      end
      wfull = 1'b0;
      #1;
      chk("t3_release_wr", 64'(wr), 64'd1);
      tick();
      chk("t3_wr_pulse", 64'(wr),     64'd0);
      chk("t3_tready",   64'(tready), 64'd1);
      chk("t3_frames",   64'(frames), 64'd3);

      // Continuous stream, no tlast: beat 5 waits through the bubble
      tvalid = 1'b1;
      tlast  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tdata = 8'(i);
         tick();
      end
      tdata = 8'h05;
      #1;
      chk("t4_w0_wr",     64'(wr),     64'd1);
      chk("t4_w0_wdata",  64'(wdata),  64'h0_0403_0201);
      chk("t4_w0_tready", 64'(tready), 64'd0);
      tick();
      for (int i = 5; i <= 8; i++) begin
         tdata = 8'(i);
         tick();
      end
      tvalid = 1'b0;
      #1;
      chk("t4_w1_wr",    64'(wr),    64'd1);
      chk("t4_w1_wdata", 64'(wdata), 64'h0_0807_0605);
      tick();
      chk("t4_frames", 64'(frames), 64'd3);

      // Single-beat frame
      beat(8'h7E, 1'b1);
      chk("t5_wdata", 64'(wdata), 64'h1_0000_007E);
      chk("t5_wr",    64'(wr),    64'd1);
      tick();
      chk("t5_frames", 64'(frames), 64'd4);

      // tvalid gap mid-word keeps the lane position
      beat(8'hD1, 1'b0);
      tick();
      tick();
      chk("t6_busy_gap", 64'(busy), 64'd1);
      beat(8'hD2, 1'b1);
      chk("t6_wdata", 64'(wdata), 64'h1_0000_D2D1);
      tick();

      // Async reset mid-word
      beat(8'h99, 1'b0);
      beat(8'h98, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_busy",  64'(busy),   64'd0);
      chk("t7_rst_wr",    64'(wr),     64'd0);
      chk("t7_rst_wdata", 64'(wdata),  64'd0);
      chk("t7_rst_frame", 64'(frames), 64'd0);
      rst_n = 1'b1;
      tick();
      beat(8'hC1, 1'b0);
      beat(8'hC2, 1'b0);
      beat(8'hC3, 1'b0);
      beat(8'hC4, 1'b1);
      chk("t7_fresh_wdata", 64'(wdata), 64'h1_C4C3_C2C1);
      tick();
      chk("t7_frames", 64'(frames), 64'd1);

      // Async reset while a word is offered to the FIFO
      beat(8'hE1, 1'b1);
      chk("t8_wr_before", 64'(wr), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t8_wr_after", 64'(wr),   64'd0);
      chk("t8_busy",     64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();

`ifdef AXIS_FIFO_WRITER_DROP_EN
      // Beats offered while holding are dropped and counted
      wfull = 1'b1;
      beat(8'h21, 1'b0);
      beat(8'h22, 1'b0);
      beat(8'h23, 1'b0);
      beat(8'h24, 1'b0);
      held = wdata;
      chk("d_held", 64'(held), 64'h0_2423_2221);
      chk("d_tready", 64'(tready), 64'd1);
      beat(8'hF1, 1'b0);
      beat(8'hF2, 1'b1);
      beat(8'hF3, 1'b0);
      chk("d_drops", 64'(drops), 64'd3);
      chk("d_wdata", 64'(wdata), 64'h0_2423_2221);
      wfull = 1'b0;
      #1;
      chk("d_wr", 64'(wr), 64'd1);
      tick();
      chk("d_frames", 64'(frames), 64'd0);
`else
      held = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net against a stuck run
   initial begin
      #200000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
